// File: rtl/lfsr_period_checker_pkg.sv
// Shared constants and state type for the LFSR run-controller / period checker.
package lfsr_pkg;

  localparam int          WIDTH      = 16;
  localparam logic [15:0] SEED       = 16'hFFFF;
  localparam int          EXP_PERIOD = 65535;

  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

endpackage

// File: rtl/lfsr_period_checker_if.sv
// Bus between the period checker and the LFSR/counter plus the board display logic.
interface lfsr_period_checker_if #(
  parameter int WIDTH = lfsr_pkg::WIDTH
);

  logic             start;
  logic [WIDTH-1:0] q_in;
  logic             max_tick;
  logic [WIDTH-1:0] ones_in;
  logic [WIDTH-1:0] zeros_in;
  logic             lfsr_rst;
  logic             sh_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic             lockup;
  logic             timeout;
  logic [WIDTH:0]   period;
  logic [WIDTH-1:0] ones_cap;
  logic [WIDTH-1:0] zeros_cap;

  modport master (
    output start, q_in, max_tick, ones_in, zeros_in,
    input  lfsr_rst, sh_en, busy, done, pass, lockup, timeout, period, ones_cap, zeros_cap
  );

  modport slave (
    input  start, q_in, max_tick, ones_in, zeros_in,
    output lfsr_rst, sh_en, busy, done, pass, lockup, timeout, period, ones_cap, zeros_cap
  );

endinterface

// File: rtl/lfsr_period_checker_shift_pacer.sv
// Divide-by-DIV prescaler: one shift pulse per DIV cycles, followed by a sample pulse.
module shift_pacer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sh_en_pulse,
  output logic sample_pulse
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] div_cnt;

  // Held at zero while disabled so the first enabled cycle issues a shift.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      div_cnt <= '0;
    end else if (div_cnt == CW'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign sh_en_pulse  = enable && (div_cnt == '0);
  assign sample_pulse = enable && (div_cnt == CW'(1));

endmodule

// File: rtl/lfsr_period_checker.sv
// Run controller for the 16-bit LFSR: resets it, paces its shifts, measures the
// period, flags lock-up/timeout and captures the ones/zeros counts for display.
module lfsr_period_checker #(
  parameter int               WIDTH      = lfsr_pkg::WIDTH,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(lfsr_pkg::SEED),
  parameter int               DIV        = 4,
  parameter int               EXP_PERIOD = lfsr_pkg::EXP_PERIOD
) (
  input logic                 clk,
  input logic                 reset,
  lfsr_period_checker_if.slave bus
);

  import lfsr_pkg::*;

  localparam logic [WIDTH:0] EXP_CNT     = (WIDTH + 1)'(EXP_PERIOD);
  localparam logic [WIDTH:0] TIMEOUT_CNT = {1'b1, {WIDTH{1'b0}}};

  state_t           state;
  logic [WIDTH:0]   shift_cnt;
  logic [WIDTH-1:0] prev_q;
  logic             run_en;
  logic             sh_en_pulse;
  logic             sample_pulse;
  logic [WIDTH:0]   count_sum;
  logic             lockup_hit;
  logic             timeout_hit;
  logic             pass_now;
  logic             terminate;

  assign run_en = (state == RUN);

  shift_pacer #(.DIV(DIV)) u_pacer (
    .clk          (clk),
    .reset        (reset),
    .enable       (run_en),
    .sh_en_pulse  (sh_en_pulse),
    .sample_pulse (sample_pulse)
  );

  assign bus.sh_en = sh_en_pulse;

  // Lock-up outranks max_tick, which outranks the timeout.
  assign count_sum   = {1'b0, bus.ones_in} + {1'b0, bus.zeros_in};
  assign lockup_hit  = (bus.q_in == prev_q);
  assign timeout_hit = (shift_cnt == TIMEOUT_CNT);
  assign pass_now    = bus.max_tick && (shift_cnt == EXP_CNT) &&
                       (count_sum == {1'b0, shift_cnt[WIDTH-1:0]});
  assign terminate   = sample_pulse && (lockup_hit || bus.max_tick || timeout_hit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      shift_cnt     <= '0;
      prev_q        <= SEED;
      bus.lfsr_rst  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.lockup    <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.period    <= '0;
      bus.ones_cap  <= '0;
      bus.zeros_cap <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= RST;
            bus.lfsr_rst <= 1'b1;
            bus.busy     <= 1'b1;
            bus.done     <= 1'b0;
            bus.pass     <= 1'b0;
            bus.lockup   <= 1'b0;
            bus.timeout  <= 1'b0;
            bus.period   <= '0;
            shift_cnt    <= '0;
            prev_q       <= SEED;
          end
        end
        RST: begin
          bus.lfsr_rst <= 1'b0;
          state        <= RUN;
        end
        RUN: begin
          if (sh_en_pulse) begin
            shift_cnt <= shift_cnt + 1'b1;
          end
          if (terminate) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.period    <= shift_cnt;
            bus.ones_cap  <= bus.ones_in;
            bus.zeros_cap <= bus.zeros_in;
            bus.lockup    <= lockup_hit;
            bus.timeout   <= !lockup_hit && !bus.max_tick && timeout_hit;
            bus.pass      <= !lockup_hit && pass_now;
          end else if (sample_pulse) begin
            prev_q <= bus.q_in;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lfsr_period_checker.md
Name: lfsr_period_checker

Overview:
- Run-controller and self-checker placed directly downstream of the 16-bit LFSR and its ones/zeros counter.
- On start, it pulses the LFSR reset, then paces the LFSR's sh_en at a fixed divided rate.
- After each shift it watches Q_out and max_tick, measures the sequence period, and detects lock-up and timeout.
- When the run ends it captures the ones/zeros counts and reports pass/fail to the board-level display logic.

Parameters:
- WIDTH, 16: LFSR state width; also the width of the ones/zeros inputs.
- SEED, 16'hFFFF: LFSR reset seed. Used as the "previous state" before the first shift.
- DIV, 4: clock cycles per shift. Legal range is 2 or more; sh_en is a 1-cycle pulse every DIV cycles.
- EXP_PERIOD, 65535: expected number of shifts until the seed recurs.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a run; accepted only in IDLE or DONE
- q_in  in  WIDTH  LFSR Q_out
- max_tick  in  1  LFSR max_tick_reg
- ones_in  in  WIDTH  counter ones
- zeros_in  in  WIDTH  counter zeros
- lfsr_rst  out  1  active-high reset pulse to the LFSR and counter
- sh_en  out  1  registered shift-enable pulse to the LFSR
- busy  out  1  high in RST and RUN
- done  out  1  high in DONE until the next start or reset
- pass  out  1  valid while done
- lockup  out  1  q_in unchanged across a shift
- timeout  out  1  2^WIDTH shifts issued without max_tick
- period  out  WIDTH+1  number of shifts at termination
- ones_cap  out  WIDTH  ones_in captured at termination
- zeros_cap  out  WIDTH  zeros_in captured at termination

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - All outputs clear to 0; period, ones_cap and zeros_cap clear to 0.
  - Internal div_cnt, shift_cnt and prev_q clear; prev_q loads SEED.
  - Reset mid-run aborts immediately; sh_en is 0 in the following cycle.
- Registers: all outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, RST, RUN, DONE.
- IDLE/DONE, start==1:
  - Go to RST.
  - Clear done, pass, lockup, timeout, period and the shift counter; set prev_q to SEED.
  - start is ignored in RST and RUN.
- RST: lfsr_rst is 1 for exactly one cycle, then go to RUN with div_cnt=0.
- RUN, pacing:
  - div_cnt counts 0..DIV-1 and wraps.
  - sh_en=1 in the cycle where div_cnt==0; shift_cnt increments by 1 on that same edge.
- RUN, sampling: in the cycle where div_cnt==1 (the cycle after the LFSR has shifted), evaluate the following in priority order:
  1. q_in==prev_q: set lockup=1 and terminate.
  2. max_tick==1: terminate.
  3. shift_cnt==2^WIDTH: set timeout=1 and terminate.
  4. Otherwise set prev_q<=q_in and continue.
- Terminate:
  - Next state is DONE.
  - period<=shift_cnt; ones_cap<=ones_in; zeros_cap<=zeros_in.
  - pass<=(!lockup && !timeout && max_tick && shift_cnt==EXP_PERIOD && ones_in+zeros_in==shift_cnt[WIDTH-1:0]).
  - The sum is computed at WIDTH+1 bits.
  - No further sh_en is issued.
- done rises on the edge that enters DONE.
  - busy falls on the same edge.
- shift_cnt is WIDTH+1 bits, so it cannot wrap before the timeout check.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package lfsr_pkg holds:
  - WIDTH, SEED, EXP_PERIOD;
  - the state enum {IDLE,RST,RUN,DONE} as localparams.
- One sub-module, shift_pacer:
  - the div_cnt prescaler with enable input (high in RUN);
  - outputs sh_en_pulse and sample_pulse (div_cnt==0 and div_cnt==1).
- The FSM, comparators and capture registers stay in the top module.

Test Plan:
1. Reset with reset=0 for 3 cycles, then release -> all outputs 0, busy=0, done=0.
2. Start with a real LFSR model (XOR max-length taps, SEED=16'hFFFF), DIV=2 -> lfsr_rst pulses once, sh_en toggles every 2 cycles, done after 65535 shifts with period=65535, ones_cap=32768, zeros_cap=32767, pass=1.
3. Start with the LFSR XNOR taps seeded 16'hFFFF (stuck state) -> after the first sh_en: lockup=1, period=1, pass=0, done=1, and no second sh_en.
4. Stub that asserts max_tick after the 10th shift, with q_in incrementing and ones_in=6, zeros_in=4 -> period=10, ones_cap=6, zeros_cap=4, pass=0 (period mismatch).
5. WIDTH=4, stub never ticks, q_in incrementing -> timeout=1 at period=16, pass=0.
6. reset=0 mid-RUN at shift 100 -> next cycle sh_en=0, state IDLE, period=0. A start pulse during RUN leaves shift_cnt and the run unaffected.
